// File: rtl/div_issue_ctrl_pkg.sv
// Shared encodings and defaults for the divider issue sequencer.
package div_issue_ctrl_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_TAG_W   = 5;
    localparam int DEF_TIMEOUT = 40;
    localparam int DEF_CNT_W   = 6;
    // Iteration count of the attached multicycle divider.
    localparam int DIV_ITER    = 34;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LAUNCH = 2'b01,
        ST_BUSY   = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Pipeline-side and divider-side signals of the divide issue sequencer.
interface div_issue_ctrl_if
    import div_issue_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = DEF_TAG_W
);
    logic             req;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [TAG_W-1:0] req_tag;
    logic             in_ready;
    logic             busy;
    logic             flush;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             div_start;
    logic [WIDTH-1:0] div_result;
    logic             div_exception;
    logic             div_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_result;
    logic             out_exception;
    logic             out_timeout;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  req, req_a, req_b, req_tag, flush,
               div_result, div_exception, div_ready,
        output in_ready, busy, div_a, div_b, div_start,
               out_valid, out_result, out_exception, out_timeout, out_tag
    );

    modport master (
        output req, req_a, req_b, req_tag, flush,
               div_result, div_exception, div_ready,
        input  in_ready, busy, div_a, div_b, div_start,
               out_valid, out_result, out_exception, out_timeout, out_tag
    );

endinterface

// File: rtl/div_issue_ctrl_reg.sv
// Enabled register with asynchronous active-low clear.
module div_issue_ctrl_reg #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Load d when enabled, otherwise hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Sequencer between execute and the multicycle divider: operand latch, start strobe,
// completion capture, divide-by-zero fast path, flush cancel and watchdog.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic            clock,
    input  logic            reset_n,
    div_issue_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_r;
    state_e           state_s;
    logic [CNT_W-1:0] wd_r;
    logic [CNT_W-1:0] wd_s;
    logic [TAG_W-1:0] tag_r;
    logic             accept_s;
    logic             b_zero_s;
    logic             cap_en_s;
    logic [WIDTH-1:0] cap_result_s;
    logic             cap_exc_s;
    logic             cap_to_s;
    logic [TAG_W-1:0] cap_tag_s;
    logic             out_exception_r;
    logic             out_timeout_r;
    logic [TAG_W-1:0] out_tag_r;

    assign accept_s = (state_r == ST_IDLE) && bus.req && !bus.flush;
    assign b_zero_s = ~|bus.req_b;

    assign bus.in_ready      = (state_r == ST_IDLE);
    assign bus.busy          = (state_r != ST_IDLE);
    assign bus.div_start     = (state_r == ST_LAUNCH);
    assign bus.out_valid     = (state_r == ST_DONE) && !bus.flush;
    assign bus.out_exception = out_exception_r;
    assign bus.out_timeout   = out_timeout_r;
    assign bus.out_tag       = out_tag_r;

    // Next state, watchdog and completion capture; flush dominates everything.
    always_comb begin
        state_s      = state_r;
        wd_s         = wd_r;
        cap_en_s     = 1'b0;
        cap_result_s = '0;
        cap_exc_s    = 1'b0;
        cap_to_s     = 1'b0;
        cap_tag_s    = tag_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (b_zero_s) begin
                        state_s   = ST_DONE;
                        cap_en_s  = 1'b1;
                        cap_exc_s = 1'b1;
                        cap_tag_s = bus.req_tag;
                    end else begin
                        state_s = ST_LAUNCH;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                wd_s = '0;
                if (bus.flush) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_BUSY: begin
                wd_s = (wd_r == WD_LAST) ? wd_r : (wd_r + CNT_W'(1));
                if (bus.flush) begin
                    state_s = ST_IDLE;
                end else if (bus.div_ready) begin
                    state_s      = ST_DONE;
                    cap_en_s     = 1'b1;
                    cap_result_s = bus.div_result;
                    cap_exc_s    = bus.div_exception;
                end else if (wd_r == WD_LAST) begin
                    state_s  = ST_DONE;
                    cap_en_s = 1'b1;
                    cap_to_s = 1'b1;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, watchdog and tag registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            wd_r    <= '0;
            tag_r   <= '0;
        end else begin
            state_r <= state_s;
            wd_r    <= wd_s;
            if (accept_s) begin
                tag_r <= bus.req_tag;
            end
        end
    end

    // Completion status held until the next completion.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_exception_r <= 1'b0;
            out_timeout_r   <= 1'b0;
            out_tag_r       <= '0;
        end else if (cap_en_s) begin
            out_exception_r <= cap_exc_s;
            out_timeout_r   <= cap_to_s;
            out_tag_r       <= cap_tag_s;
        end
    end

    div_issue_ctrl_reg #(.W(WIDTH)) u_a_reg (
        .clock  (clock),
        .reset_n(reset_n),
        .en     (accept_s),
        .d      (bus.req_a),
        .q      (bus.div_a)
    );

    div_issue_ctrl_reg #(.W(WIDTH)) u_b_reg (
        .clock  (clock),
        .reset_n(reset_n),
        .en     (accept_s),
        .d      (bus.req_b),
        .q      (bus.div_b)
    );

    div_issue_ctrl_reg #(.W(WIDTH)) u_res_reg (
        .clock  (clock),
        .reset_n(reset_n),
        .en     (cap_en_s),
        .d      (cap_result_s),
        .q      (bus.out_result)
    );

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural 34-count divider, vector table and scoreboard.
module tb_div_issue_ctrl;
    import div_issue_ctrl_pkg::*;

    localparam int NOM_LAT = DIV_ITER + 2;       // start edge + 34 counts + capture edge
    localparam int TO_LAT  = DEF_TIMEOUT + 1;    // launch cycle + 40 BUSY cycles
    localparam int RDY_CNT = DIV_ITER + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] res;
        logic        exc;
        logic        to;
        int          lat;
        int          starts;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic        to;
        logic [4:0]  tag;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    logic tie_low;
    int   dcnt;
    int   n_tests;
    int   n_fail;
    int   starts;
    logic got_valid;
    logic unstable;
    logic prev_busy;
    logic [31:0] pa;
    logic [31:0] pb;
    exp_t sbq[$];
    vec_t vecs[6];

    always #5 clock = ~clock;

    div_issue_ctrl_if #(.WIDTH(32), .TAG_W(5)) bus ();

    div_issue_ctrl #(.WIDTH(32), .TAG_W(5), .TIMEOUT(40), .CNT_W(6)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Divider stand-in: counts from the sampled start, ready for one cycle after count 35.
    always @(posedge clock) begin
        if (bus.div_start) dcnt <= 1;
        else if (dcnt > 0 && dcnt < RDY_CNT) dcnt <= dcnt + 1;
        else dcnt <= 0;
    end
    assign bus.div_ready     = (dcnt == RDY_CNT) && !tie_low;
    assign bus.div_exception = (bus.div_b == 32'd0);
    assign bus.div_result    = (bus.div_b == 32'd0) ? 32'd0 :
                               32'($signed(bus.div_a) / $signed(bus.div_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Advance one clock and sample #1 later; scoreboard any completion.
    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        if (bus.div_start) starts++;
        if (bus.busy && prev_busy && (bus.div_a !== pa || bus.div_b !== pb)) unstable = 1'b1;
        pa = bus.div_a;
        pb = bus.div_b;
        prev_busy = bus.busy;
        if (bus.out_valid) begin
            got_valid = 1'b1;
            chk("valid_expected", 32'(sbq.size()), 32'd1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("out_result", bus.out_result, e.res);
                chk1("out_exception", bus.out_exception, e.exc);
                chk1("out_timeout", bus.out_timeout, e.to);
                chk("out_tag", {27'd0, bus.out_tag}, {27'd0, e.tag});
            end
        end
    endtask

    task automatic run_op(input vec_t v);
        int t;
        int lat;
        exp_t e;
        t = 0;
        while (!bus.in_ready && t < 100) begin
            tick();
            t++;
        end
        chk1("in_ready_before_req", bus.in_ready, 1'b1);
        starts = 0;
        unstable = 1'b0;
        got_valid = 1'b0;
        bus.req = 1'b1;
        bus.req_a = v.a;
        bus.req_b = v.b;
        bus.req_tag = v.tag;
        e.res = v.res;
        e.exc = v.exc;
        e.to = v.to;
        e.tag = v.tag;
        sbq.push_back(e);
        tick();
        bus.req = 1'b0;
        bus.req_a = $urandom;
        bus.req_b = $urandom;
        bus.req_tag = 5'($urandom);
        chk1("busy_after_accept", bus.busy, 1'b1);
        lat = 0;
        while (!got_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'(v.lat));
        chk("start_pulses", 32'(starts), 32'(v.starts));
        chk1("operands_stable", unstable, 1'b0);
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        starts = 0;
        prev_busy = 1'b0;
        pa = 32'd0;
        pb = 32'd0;
        tie_low = 1'b0;
        reset_n = 1'b0;
        bus.req = 1'b0;
        bus.req_a = 32'd0;
        bus.req_b = 32'd0;
        bus.req_tag = 5'd0;
        bus.flush = 1'b0;

        vecs[0] = '{32'd100,        32'd7,          5'd3,  32'd14,         1'b0, 1'b0, NOM_LAT, 1};
        vecs[1] = '{32'hFFFF_FF9C,  32'd7,          5'd4,  32'hFFFF_FFF2,  1'b0, 1'b0, NOM_LAT, 1};
        vecs[2] = '{32'd123,        32'd0,          5'd9,  32'd0,          1'b1, 1'b0, 0,       0};
        vecs[3] = '{32'd7,          32'hFFFF_FFFE,  5'd5,  32'hFFFF_FFFD,  1'b0, 1'b0, NOM_LAT, 1};
        vecs[4] = '{32'h8000_0000,  32'd1,          5'd6,  32'h8000_0000,  1'b0, 1'b0, NOM_LAT, 1};
        vecs[5] = '{32'd1000,       32'd1000,       5'd31, 32'd1,          1'b0, 1'b0, NOM_LAT, 1};

        tick();
        tick();
        chk1("rst_in_ready", bus.in_ready, 1'b1);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_div_start", bus.div_start, 1'b0);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_div_a", bus.div_a, 32'd0);
        chk("rst_out_result", bus.out_result, 32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_op(vecs[i]);

        tick();
        tick();
        chk("hold_result", bus.out_result, 32'd1);
        chk("hold_tag", {27'd0, bus.out_tag}, 32'd31);

        // Flush in IDLE blocks the accept.
        bus.req = 1'b1;
        bus.req_a = 32'd40;
        bus.req_b = 32'd5;
        bus.flush = 1'b1;
        tick();
        bus.req = 1'b0;
        bus.flush = 1'b0;
        chk1("idle_flush_no_accept", bus.busy, 1'b0);

        // Flush in BUSY cycle 10, wait out the stale divider ready, then a fresh op.
        bus.req = 1'b1;
        bus.req_a = 32'd200;
        bus.req_b = 32'd7;
        bus.req_tag = 5'd2;
        tick();
        bus.req = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk1("busy_flush_idle", bus.in_ready, 1'b1);
        for (int i = 0; i < 40; i++) tick();
        chk("flush_tag_held", {27'd0, bus.out_tag}, 32'd31);
        run_op('{32'd9, 32'd3, 5'd7, 32'd3, 1'b0, 1'b0, NOM_LAT, 1});

        // Flush during DONE suppresses the completion pulse.
        bus.req = 1'b1;
        bus.req_a = 32'd20;
        bus.req_b = 32'd0;
        bus.req_tag = 5'd10;
        @(posedge clock);
        #1;
        bus.req = 1'b0;
        bus.flush = 1'b1;
        #1;
        chk1("done_flush_busy", bus.busy, 1'b1);
        chk1("done_flush_no_valid", bus.out_valid, 1'b0);
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        prev_busy = bus.busy;
        chk1("done_flush_idle", bus.in_ready, 1'b1);

        // Divider never answers: watchdog completion.
        tie_low = 1'b1;
        run_op('{32'd77, 32'd7, 5'd12, 32'd0, 1'b0, 1'b1, TO_LAT, 1});
        tie_low = 1'b0;

        // Async reset mid-BUSY aborts with everything cleared.
        bus.req = 1'b1;
        bus.req_a = 32'd500;
        bus.req_b = 32'd5;
        bus.req_tag = 5'd13;
        tick();
        bus.req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #3;
        reset_n = 1'b0;
        #1;
        chk1("arst_busy", bus.busy, 1'b0);
        chk1("arst_in_ready", bus.in_ready, 1'b1);
        chk1("arst_div_start", bus.div_start, 1'b0);
        chk1("arst_out_valid", bus.out_valid, 1'b0);
        chk("arst_div_a", bus.div_a, 32'd0);
        chk("arst_div_b", bus.div_b, 32'd0);
        chk("arst_out_result", bus.out_result, 32'd0);
        chk1("arst_out_exception", bus.out_exception, 1'b0);
        chk1("arst_out_timeout", bus.out_timeout, 1'b0);
        chk("arst_out_tag", {27'd0, bus.out_tag}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        run_op('{32'd50, 32'd5, 5'd14, 32'd10, 1'b0, 1'b0, NOM_LAT, 1});
        for (int i = 0; i < 45; i++) tick();
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
